button_inc_debouncer: RTL and testbench

Conditions a raw mechanical push-button into single-cycle increment strobes for the downstream 8-bit event counter's `inc` input. It synchronizes the asynchronous button, rejects contact bounce with a programmable stability window, and emits one `inc` pulse per confirmed press. An optional hold-to-repeat mode adds further pulses while the button stays down.

---
 rtl/button_inc_debouncer.sv | 170 +++++++++++++++++
 tb/tb_button_inc_debouncer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_inc_debouncer.sv
// -----------------------------------------------------------------------------
// button_inc_debouncer
//
// Turns a raw mechanical push-button into clean single-cycle increment strobes
// for a downstream event counter. The button is brought into the clk domain
// through a two-flop synchronizer. A four-state FSM then rejects contact bounce
// using a programmable stability window. An optional hold-to-repeat mode emits
// further strobes while the button stays down.
//
// Parameters:
//   DEBOUNCE_CYCLES : stability window for accepting a press or a release (>= 2)
//   REPEAT_EN       : 1 enables auto-repeat strobes while the button is held
//   REPEAT_DELAY    : cycles from entry into HELD until the first repeat (>= 2)
//   REPEAT_PERIOD   : cycles between later repeat strobes (>= 2)
//
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high reset
//   btn_in    : raw button, asynchronous to clk, active-high
//   inc       : registered single-cycle increment strobe
//   btn_level : registered debounced button level
// -----------------------------------------------------------------------------
module button_inc_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic inc,
  output logic btn_level
);

  // Each counter only ever holds 0 .. (limit-1), so it never needs to wrap.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_W   = $clog2(RPT_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer. Only btn_s is used past this point.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_reg;
  logic       btn_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], btn_in};
    end
  end

  assign btn_s = sync_reg[1];

  // ---------------------------------------------------------------------------
  // FSM state, counters and registered outputs
  // ---------------------------------------------------------------------------
  state_t           state_reg,     state_next;
  logic [DB_W-1:0]  db_cnt_reg,    db_cnt_next;
  logic [RPT_W-1:0] rpt_cnt_reg,   rpt_cnt_next;
  logic             rpt_phase_reg, rpt_phase_next;  // 0: first delay, 1: periodic
  logic             inc_reg,       inc_next;
  logic             level_reg,     level_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RELEASED;
      db_cnt_reg    <= '0;
      rpt_cnt_reg   <= '0;
      rpt_phase_reg <= 1'b0;
      inc_reg       <= 1'b0;
      level_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      db_cnt_reg    <= db_cnt_next;
      rpt_cnt_reg   <= rpt_cnt_next;
      rpt_phase_reg <= rpt_phase_next;
      inc_reg       <= inc_next;
      level_reg     <= level_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    db_cnt_next    = db_cnt_reg;
    rpt_cnt_next   = rpt_cnt_reg;
    rpt_phase_next = rpt_phase_reg;
    inc_next       = 1'b0;
    level_next     = level_reg;

    case (state_reg)
      RELEASED: begin
        if (btn_s) begin
          state_next  = PRESS_WAIT;
          db_cnt_next = '0;
        end
      end

      PRESS_WAIT: begin
        if (!btn_s) begin
          // Bounce: drop back without touching the outputs.
          state_next = RELEASED;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next     = HELD;
          level_next     = 1'b1;
          inc_next       = 1'b1;
          rpt_cnt_next   = '0;
          rpt_phase_next = 1'b0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end

      HELD: begin
        if (!btn_s) begin
          state_next  = RELEASE_WAIT;
          db_cnt_next = '0;
        end else if (REPEAT_EN) begin
          // The repeat counter is cleared on every HELD entry, so the first
          // strobe lands REPEAT_DELAY edges after entry and later ones every
          // REPEAT_PERIOD edges. Both limits are >= 2, so a repeat strobe can
          // never sit next to the press strobe or to another repeat.
          if (rpt_cnt_reg == (rpt_phase_reg ? PERIOD_LAST : DELAY_LAST)) begin
            inc_next       = 1'b1;
            rpt_cnt_next   = '0;
            rpt_phase_next = 1'b1;
          end else begin
            rpt_cnt_next = rpt_cnt_reg + 1'b1;
          end
        end
      end

      RELEASE_WAIT: begin
        if (btn_s) begin
          // Release bounce: back to HELD with repeat timing restarted from
          // the delay phase.
          state_next     = HELD;
          rpt_cnt_next   = '0;
          rpt_phase_next = 1'b0;
        end else if (db_cnt_reg == DB_LAST) begin
          state_next = RELEASED;
          level_next = 1'b0;
        end else begin
          db_cnt_next = db_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = RELEASED;
      end
    endcase
  end

  assign inc       = inc_reg;
  assign btn_level = level_reg;

endmodule

// File: tb/tb_button_inc_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_inc_debouncer
//
// Drives two instances in parallel from the same button and reset: one with
// auto-repeat off (dut0) and one with auto-repeat on (dut1). A cycle-level
// behavioural model predicts both outputs from the debounce rules and is
// compared on every falling edge. Directed checks pin latencies, pulse counts
// and an attached 8-bit event counter to hand-computed values.
// -----------------------------------------------------------------------------
module tb_button_inc_debouncer;

  localparam int DC = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic inc0, lvl0, inc1, lvl1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_inc_debouncer #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut0 (
    .clk(clk), .reset(reset), .btn_in(btn_in), .inc(inc0), .btn_level(lvl0)
  );

  button_inc_debouncer #(
    .DEBOUNCE_CYCLES(DC), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut1 (
    .clk(clk), .reset(reset), .btn_in(btn_in), .inc(inc1), .btn_level(lvl1)
  );

  // Downstream 8-bit event counter fed by the non-repeating instance.
  logic [7:0] cnt8;
  always @(posedge clk) begin
    if (reset) cnt8 <= 8'd0;
    else if (inc0) cnt8 <= cnt8 + 8'd1;
  end

  // ---------------------------------------------------------------------------
  // Behavioural model. Debounced level flips once DC+1 consecutive
  // synchronized samples disagree with it; hold age restarts whenever the held
  // button is (re)confirmed and repeat strobes fall on age RD, RD+RP, ...
  // ---------------------------------------------------------------------------
  bit m_s1, m_s2, m_bs, m_lvl;
  int m_run, m_age;
  bit e_inc0, e_inc1, e_lvl;
  bit model_valid = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_age = 0;
        e_inc0 = 0; e_inc1 = 0; e_lvl = 0;
        model_valid = 1'b1;
      end else begin
        m_bs = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_in;
        e_inc0 = 0;
        e_inc1 = 0;
        if (m_bs != m_lvl) begin
          m_run++;
          if (m_run == DC + 1) begin
            m_lvl = m_bs;
            m_run = 0;
            if (m_lvl) begin
              e_inc0 = 1;
              e_inc1 = 1;
              m_age  = 0;
            end
          end
        end else begin
          if (m_lvl) begin
            if (m_run > 0) begin
              m_age = 0;
            end else begin
              m_age++;
              if (m_age == RD || (m_age > RD && ((m_age - RD) % RP) == 0)) e_inc1 = 1;
            end
          end
          m_run = 0;
        end
        e_lvl = m_lvl;
      end
    end
  end

  task automatic cmp_bit(input string name, input logic got, input bit exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        cmp_bit("model_inc0", inc0, e_inc0);
        cmp_bit("model_lvl0", lvl0, e_lvl);
        cmp_bit("model_inc1", inc1, e_inc1);
        cmp_bit("model_lvl1", lvl1, e_lvl);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed helpers
  // ---------------------------------------------------------------------------
  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected event (0: inc0 high, 1: lvl0 low, 2: inc1 high)
  // and checks the edge offset from the first edge after the call.
  task automatic wait_for(input int sel, input int exp_off, input string name, output int pulses);
    int off;
    off = -1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (inc0 === 1'b1) pulses++;
      if ((sel == 0 && inc0 === 1'b1) || (sel == 1 && lvl0 === 1'b0) ||
          (sel == 2 && inc1 === 1'b1)) begin
        off = k;
        break;
      end
    end
    check_int(name, off, exp_off);
  endtask

  task automatic hold(input int n, output int p0, output int p1);
    p0 = 0;
    p1 = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (inc0 === 1'b1) p0++;
      if (inc1 === 1'b1) p1++;
    end
  endtask

  task automatic press_release();
    int p0, p1;
    btn_in = 1'b1;
    hold(10, p0, p1);
    btn_in = 1'b0;
    hold(10, p0, p1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int p, p0, p1, off, cnt, lowseen;

    // 1. Reset for 3 cycles with the button already held.
    reset  = 1'b1;
    btn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_int("reset_inc", int'(inc0), 0);
      check_int("reset_level", int'(lvl0), 0);
    end
    reset = 1'b0;
    wait_for(0, DC + 2, "held_through_reset_latency", p);
    hold(20, p0, p1);
    check_int("held_through_reset_single_inc", p0, 0);
    btn_in = 1'b0;
    wait_for(1, DC + 2, "held_through_reset_release", p);
    hold(10, p0, p1);

    // 2. Clean press, held 40 cycles, then released.
    btn_in = 1'b1;
    wait_for(0, DC + 2, "press_latency", p);
    check_int("press_level", int'(lvl0), 1);
    step();
    check_int("press_inc_width", int'(inc0), 0);
    hold(33, p0, p1);
    check_int("press_no_repeat", p0, 0);
    btn_in = 1'b0;
    wait_for(1, DC + 2, "release_latency", p);
    check_int("release_no_inc", p, 0);
    hold(10, p0, p1);

    // 3a. Toggle every 2 cycles for 20 cycles, then stay high.
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0);
      hold(2, p0, p1);
      cnt += p0;
    end
    check_int("bounce_no_inc", cnt, 0);
    btn_in = 1'b1;
    wait_for(0, DC + 2, "bounce_then_press_latency", p);
    btn_in = 1'b0;
    wait_for(1, DC + 2, "bounce_release_latency", p);
    hold(10, p0, p1);

    // 3b. Isolated 3-cycle high glitch.
    btn_in = 1'b1;
    hold(3, p0, p1);
    cnt = p0;
    btn_in = 1'b0;
    hold(15, p0, p1);
    check_int("glitch_no_inc", cnt + p0, 0);
    check_int("glitch_level", int'(lvl0), 0);

    // 4. Auto-repeat: pulses at H, H+20, H+28, H+36, H+44, H+52.
    btn_in = 1'b1;
    wait_for(2, DC + 2, "repeat_entry_latency", p);
    cnt = 0;
    p0 = 0;
    for (int j = 1; j < 60; j++) begin
      step();
      if (inc0 === 1'b1) p0++;
      if (inc1 === 1'b1) begin
        cnt++;
        check_int("repeat_offset", j, RD + RP * (cnt - 1));
      end
    end
    check_int("repeat_pulse_count", cnt + 1, 6);
    check_int("no_repeat_when_disabled", p0, 0);

    // 5. Release bounce while held. The strobe due at H+60 occurs first.
    hold(2, p0, p1);
    check_int("repeat_at_60", p1, 1);
    btn_in = 1'b0;              // first low sample at edge D
    lowseen = 0;
    hold(2, p0, p1);
    btn_in = 1'b1;
    off = -1;
    for (int k = 2; k < 40; k++) begin
      step();
      if (lvl0 !== 1'b1 || lvl1 !== 1'b1) lowseen++;
      if (inc0 === 1'b1) lowseen++;
      if (inc1 === 1'b1) begin
        off = k;
        break;
      end
    end
    check_int("dip_level_held", lowseen, 0);
    check_int("dip_next_repeat_offset", off, 4 + RD);
    btn_in = 1'b0;
    hold(12, p0, p1);
    check_int("dip_final_release", int'(lvl1), 0);

    // 6. Integration with the 8-bit counter.
    reset = 1'b1;
    hold(2, p0, p1);
    reset = 1'b0;
    check_int("counter_cleared", int'(cnt8), 0);
    for (int i = 0; i < 5; i++) press_release();
    check_int("counter_after_5", int'(cnt8), 5);
    for (int i = 0; i < 255; i++) press_release();
    check_int("counter_after_260_wrap", int'(cnt8), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
